// File: rtl/div_seq_pkg.sv
// Shared encodings for div_sequencer: op codes, FSM state codes, ALU op, special values.
// Pure declarations; no latency or flow control of its own.
// Imported by div_sequencer.
package div_seq_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_NEGA = 3'd1;
   localparam logic [2:0] S_NEGB = 3'd2;
   localparam logic [2:0] S_ITER = 3'd3;
   localparam logic [2:0] S_FIX  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [3:0] ALUOP_SLTU = 4'b0111;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   // op[0] set means unsigned (DIVU/REMU)
   function automatic logic op_is_signed(input logic [1:0] o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/div_sequencer.sv
// RV32M divide/remainder sequencer using the shared ALU adder; one restoring step per cycle.
// Latency: done at T+36 normal, T+2 for div-by-zero/overflow (and early-out with DIVSEQ_EARLY_OUT_EN).
// No backpressure: start is only sampled in IDLE; flush aborts any operation with no done.
module div_sequencer
   import div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   input  logic [XLEN-1:0] alu_adder_out,
   input  logic            alu_cmp_out
);

   logic [2:0]      state;
   logic [1:0]      op_q;
   logic            neg1;
   logic            neg2;
   logic            bypass;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [4:0]      count;

   logic [XLEN-1:0] shifted;
   logic            ge;
   logic [XLEN-1:0] sel;
   logic            neg_res;
   logic            is_signed;
   logic            div_zero;
   logic            overflow;
   logic            early;

   assign alu_op    = ALUOP_SLTU;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE) && !flush;
   assign is_signed = op_is_signed(op);
   assign div_zero  = (rs2 == '0);
   assign overflow  = is_signed && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

   assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};
   assign ge      = rem[XLEN-1] | ~alu_cmp_out;
   assign sel     = op_q[1] ? rem : quo;

   always_comb begin
      neg_res = 1'b0;
      if (!bypass) begin
         if (op_q == OP_DIV)      neg_res = neg1 ^ neg2;
         else if (op_q == OP_REM) neg_res = neg1;
      end
   end

`ifdef DIVSEQ_EARLY_OUT_EN
   assign early = start && op[0] && alu_cmp_out && !div_zero;
`else
   assign early = 1'b0;
`endif

   always_comb begin
      alu_in1 = '0;
      alu_in2 = '0;
      case (state)
`ifdef DIVSEQ_EARLY_OUT_EN
         S_IDLE: if (start && op[0]) begin
            alu_in1 = rs1;
            alu_in2 = rs2;
         end
`endif
         S_NEGA: alu_in2 = quo;
         S_NEGB: alu_in2 = dvs;
         S_ITER: begin
            alu_in1 = shifted;
            alu_in2 = dvs;
         end
         S_FIX:  alu_in2 = sel;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         op_q   <= OP_DIV;
         neg1   <= 1'b0;
         neg2   <= 1'b0;
         bypass <= 1'b0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         count  <= '0;
         result <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q <= op;
               neg1 <= is_signed & rs1[XLEN-1];
               neg2 <= is_signed & rs2[XLEN-1];
               dvs  <= rs2;
               // Short-path results are staged in quo/rem and published by FIX
               // (unnegated), which gives the two-cycle special-case latency.
               if (div_zero) begin
                  quo    <= ALL_ONES;
                  rem    <= rs1;
                  bypass <= 1'b1;
                  state  <= S_FIX;
               end else if (overflow) begin
                  quo    <= INT_MIN;
                  rem    <= '0;
                  bypass <= 1'b1;
                  state  <= S_FIX;
               end else if (early) begin
                  quo    <= '0;
                  rem    <= rs1;
                  bypass <= 1'b1;
                  state  <= S_FIX;
               end else begin
                  quo    <= rs1;
                  bypass <= 1'b0;
                  state  <= S_NEGA;
               end
            end
            S_NEGA: begin
               if (neg1) quo <= alu_adder_out;
               state <= S_NEGB;
            end
            S_NEGB: begin
               if (neg2) dvs <= alu_adder_out;
               rem   <= '0;
               count <= 5'd31;
               state <= S_ITER;
            end
            S_ITER: begin
               rem <= ge ? alu_adder_out : shifted;
               quo <= {quo[XLEN-2:0], ge};
               if (count == 5'd0) state <= S_FIX;
               else               count <= count - 5'd1;
            end
            S_FIX: begin
               result <= neg_res ? alu_adder_out : sel;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural ALU and reference divider.
module tb_div_sequencer;
   import div_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic        busy, done;
   logic [31:0] result;
   logic [3:0]  alu_op;
   logic [31:0] alu_in1, alu_in2, alu_adder_out;
   logic        alu_cmp_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign alu_adder_out = alu_in1 - alu_in2;
   assign alu_cmp_out   = (alu_in1 < alu_in2);

   div_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .flush(flush), .busy(busy), .done(done), .result(result),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_adder_out(alu_adder_out), .alu_cmp_out(alu_cmp_out)
   );

   // RISC-V semantics from plain arithmetic; latency from the operand class.
   task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] exp_res, output int exp_lat);
      logic [31:0] q, r;
      int sa, sb;
      bit sgn = (o == OP_DIV) || (o == OP_REM);
      exp_lat = 36;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a; exp_lat = 2;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0; exp_lat = 2;
      end else if (sgn) begin
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
`ifdef DIVSEQ_EARLY_OUT_EN
         if (a < b) exp_lat = 2;
`endif
      end
      exp_res = o[1] ? r : q;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input string nm);
      logic [31:0] exp_res;
      int exp_lat, lat;
      bit seen, busy_bad, aluop_bad;
      ref_model(o, a, b, exp_res, exp_lat);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
      seen = 0; lat = 0; busy_bad = 0; aluop_bad = 0;
      for (int k = 1; k <= 60 && !seen; k++) begin
         @(negedge clk);
         if (!busy) busy_bad = 1;
         if (alu_op !== ALUOP_SLTU) aluop_bad = 1;
         if (done === 1'b1) begin seen = 1; lat = k; end
         if (poke && exp_lat > 4 && k == 3) start = 1'b1;
         if (k == 4) start = 1'b0;
      end
      checks++;
      if (!seen || lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, lat, seen, exp_lat);
      end
      checks++;
      if (result !== exp_res) begin
         failures++;
         $display("FAIL %s result: got %h expected %h (op=%0d a=%h b=%h)", nm, result, exp_res, o, a, b);
      end
      checks++;
      if (busy_bad || aluop_bad) begin
         failures++;
         $display("FAIL %s busy/alu_op window: busy_bad=%0d aluop_bad=%0d expected 0/0", nm, busy_bad, aluop_bad);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s post-done idle: busy=%b done=%b expected 0/0", nm, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || alu_op !== 4'b0111 ||
          alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b result=%h alu_op=%h in1=%h in2=%h expected 0/0/0/7/0/0",
                  busy, done, result, alu_op, alu_in1, alu_in2);
      end
   endtask

   task automatic test_directed();
      run_op(OP_DIVU, 100, 7, 1'b1, "divu_100_7");
      run_op(OP_REMU, 100, 7, 1'b0, "remu_100_7");
      run_op(OP_DIV, 32'hFFFF_FFF9, 2, 1'b0, "div_m7_2");
      run_op(OP_REM, 32'hFFFF_FFF9, 2, 1'b0, "rem_m7_2");
      run_op(OP_DIV, 7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
      run_op(OP_REM, 7, 32'hFFFF_FFFE, 1'b0, "rem_7_m2");
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
      run_op(OP_DIVU, 5, 0, 1'b0, "divu_by0");
      run_op(OP_REM, 5, 0, 1'b0, "rem_by0");
      run_op(OP_DIV, 32'hFFFF_FFFF, 0, 1'b0, "div_m1_by0");
      run_op(OP_DIVU, 3, 10, 1'b0, "divu_3_10");
      run_op(OP_REMU, 3, 10, 1'b0, "remu_3_10");
   endtask

   task automatic test_flush();
      logic [31:0] prev, exp_res;
      int exp_lat, lat;
      bit spurious;
      prev = result;
      spurious = 0;
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done === 1'b1) spurious = 1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      start = 1'b1; op = OP_REMU; rs1 = 32'd1000; rs2 = 32'd7;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== prev || spurious) begin
         failures++;
         $display("FAIL flush_abort: busy=%b done=%b result=%h spurious=%0d expected 0/0/%h/0",
                  busy, done, result, spurious, prev);
      end
      ref_model(OP_REMU, 1000, 7, exp_res, exp_lat);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         @(negedge clk);
         if (done === 1'b1) lat = k;
      end
      checks++;
      if (lat != 36 || result !== exp_res) begin
         failures++;
         $display("FAIL flush_restart: lat=%0d result=%h expected 36/%h", lat, result, exp_res);
      end
      @(negedge clk);
      // flush in IDLE drops a same-cycle start
      start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1 = 9; rs2 = 4;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_drop: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_op();
      bit spurious = 0;
      @(negedge clk);
      start = 1'b1; op = OP_DIV; rs1 = 32'd12345; rs2 = 32'd11;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid_op: busy=%b result=%h expected 0/0", busy, result);
      end
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) spurious = 1;
      end
      checks++;
      if (spurious) begin
         failures++;
         $display("FAIL reset_no_done: activity seen=1 expected 0");
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [1:0] o;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 6))
            0: b = 0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 20);
            3: begin a = $urandom_range(0, 50); b = $urandom_range(1, 100); end
            4: b = -$urandom_range(1, 20);
            default: ;
         endcase
         run_op(o, a, b, 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush();
      test_random();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
